// File: rtl/legion_mem_pkg.sv
// legion_mem_pkg: shared widths, idle instruction and loader state type for the Legion H memory responder.
package legion_mem_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int INSTR_W_DEF = 9;
   localparam int DATA_W_DEF = 8;
   localparam logic [8:0] NOP_INSTR = 9'b111000000;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
endpackage

// File: rtl/memoria_dp.sv
// memoria_dp: simple dual-port synchronous RAM, one write port and one registered read port (write-first).
module memoria_dp #(
   parameter int W = 8,
   parameter int D = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [$clog2(D)-1:0] waddr,
   input  logic [W-1:0]         wdata,
   input  logic                 re,
   input  logic [$clog2(D)-1:0] raddr,
   output logic [W-1:0]         rdata
);
   logic [W-1:0] mem [D];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // Only the read register is reset; array contents survive reset.
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata <= '0;
      else if (re) rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/memoria_legion_h.sv
// memoria_legion_h: Legion H instruction/data memory responder with a sequential program loader
// that holds the CPU in reset until the program is in place.
module memoria_legion_h #(
   parameter int ADDR_W = legion_mem_pkg::ADDR_W_DEF,
   parameter int INSTR_W = legion_mem_pkg::INSTR_W_DEF,
   parameter int DATA_W = legion_mem_pkg::DATA_W_DEF
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic [ADDR_W-1:0]  i_Direcciones_Instrucciones,
   output logic [INSTR_W-1:0] o_Instrucciones,
   input  logic [ADDR_W-1:0]  i_Direcciones_Datos,
   input  logic [DATA_W-1:0]  i_Bus_Datos,
   input  logic               i_Lectura_Escritura,
   output logic [DATA_W-1:0]  o_Bus_Datos,
   output logic               o_Cpu_Rst,
   input  logic               i_Prog_Start,
   input  logic               i_Prog_Valid,
   input  logic [INSTR_W-1:0] i_Prog_Data,
   input  logic               i_Prog_End,
   input  logic               i_Run,
   output logic [ADDR_W-1:0]  o_Prog_Count,
   output logic               o_Prog_Full
);
   import legion_mem_pkg::*;
   state_t state;
   logic [ADDR_W-1:0] count;
   logic [INSTR_W-1:0] fetch;
   logic full, fetch_ok, run, prog_we, data_we;
   assign run = state == RUN;
   assign prog_we = state == LOAD && !i_Prog_Start && i_Prog_Valid;
   assign data_we = run && i_Lectura_Escritura;
   // fetch_ok is low on the first RUN cycle, so NOP shows until a real fetch lands.
   assign o_Instrucciones = fetch_ok ? fetch : INSTR_W'(NOP_INSTR);
   assign o_Prog_Count = count;
   assign o_Prog_Full = full;
   memoria_dp #(.W(INSTR_W), .D(1 << ADDR_W)) u_instr (
      .clk(i_Clk), .rst(i_Rst), .we(prog_we), .waddr(count), .wdata(i_Prog_Data),
      .re(run), .raddr(i_Direcciones_Instrucciones), .rdata(fetch)
   );
   memoria_dp #(.W(DATA_W), .D(1 << ADDR_W)) u_data (
      .clk(i_Clk), .rst(i_Rst), .we(data_we), .waddr(i_Direcciones_Datos), .wdata(i_Bus_Datos),
      .re(run), .raddr(i_Direcciones_Datos), .rdata(o_Bus_Datos)
   );
   always_ff @(posedge i_Clk or posedge i_Rst)
      if (i_Rst) begin
         state <= IDLE;
         count <= '0;
         full <= 1'b0;
         o_Cpu_Rst <= 1'b1;
         fetch_ok <= 1'b0;
      end else begin
         fetch_ok <= run && !i_Prog_Start;
         case (state)
            IDLE:
               if (i_Prog_Start) begin
                  state <= LOAD;
                  count <= '0;
                  full <= 1'b0;
               end else if (i_Run) begin
                  state <= RUN;
                  o_Cpu_Rst <= 1'b0;
               end
            LOAD:
               if (i_Prog_Start) begin
                  count <= '0;
                  full <= 1'b0;
               end else begin
                  if (i_Prog_Valid) begin
                     count <= count + 1'b1;
                     if (&count) begin
                        full <= 1'b1;
                        state <= RUN;
                        o_Cpu_Rst <= 1'b0;
                     end
                  end
                  if (i_Prog_End) begin
                     state <= RUN;
                     o_Cpu_Rst <= 1'b0;
                  end
               end
            default:
               if (i_Prog_Start) begin
                  state <= LOAD;
                  count <= '0;
                  full <= 1'b0;
                  o_Cpu_Rst <= 1'b1;
               end
         endcase
      end
endmodule

// File: tb/tb_memoria_legion_h.sv
// tb_memoria_legion_h: randomized and directed bench for memoria_legion_h against a behavioural model.
module tb_memoria_legion_h;
   localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;
   logic clk = 0, rst = 1;
   logic [7:0] ia = 0, da = 0, dw = 0;
   logic [8:0] pd = 0;
   logic rw = 0, start = 0, valid = 0, pend = 0, run = 0;
   logic [8:0] instr;
   logic [7:0] data, count;
   logic cpu_rst, full;
   int n_tests = 0, n_fail = 0;
   int mode, old_mode, m_cnt;
   bit m_full, e_instr_k, e_data_k, fk;
   logic [8:0] imem [256];
   bit iknown [256];
   logic [7:0] dmem [256];
   bit dknown [256];
   logic [8:0] e_instr, f;
   logic [7:0] e_data;
   logic [8:0] w [10];

   memoria_legion_h dut (
      .i_Clk(clk), .i_Rst(rst),
      .i_Direcciones_Instrucciones(ia), .o_Instrucciones(instr),
      .i_Direcciones_Datos(da), .i_Bus_Datos(dw), .i_Lectura_Escritura(rw), .o_Bus_Datos(data),
      .o_Cpu_Rst(cpu_rst), .i_Prog_Start(start), .i_Prog_Valid(valid), .i_Prog_Data(pd),
      .i_Prog_End(pend), .i_Run(run), .o_Prog_Count(count), .o_Prog_Full(full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one step per clock edge, from the memory's observable rules.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mode = M_IDLE;
         m_cnt = 0;
         m_full = 0;
         e_instr = 9'h1C0;
         e_instr_k = 1;
         e_data = 0;
         e_data_k = 1;
      end else begin
         old_mode = mode;
         f = imem[ia];
         fk = iknown[ia];
         if (old_mode == M_RUN) begin
            if (rw) begin
               dmem[da] = dw;
               dknown[da] = 1;
               e_data = dw;
               e_data_k = 1;
            end else begin
               e_data = dmem[da];
               e_data_k = dknown[da];
            end
            if (start) begin mode = M_LOAD; m_cnt = 0; m_full = 0; end
         end else if (old_mode == M_IDLE) begin
            if (start) begin mode = M_LOAD; m_cnt = 0; m_full = 0; end
            else if (run) mode = M_RUN;
         end else if (start) begin
            m_cnt = 0;
            m_full = 0;
         end else begin
            if (valid) begin
               imem[m_cnt] = pd;
               iknown[m_cnt] = 1;
               if (m_cnt == 255) begin m_full = 1; mode = M_RUN; end
               m_cnt = (m_cnt + 1) % 256;
            end
            if (pend) mode = M_RUN;
         end
         if (old_mode == M_RUN && mode == M_RUN) begin
            e_instr = f;
            e_instr_k = fk;
         end else begin
            e_instr = 9'h1C0;
            e_instr_k = 1;
         end
      end
   end

   always @(negedge clk) if (!rst) begin
      chk("m_cpu_rst", cpu_rst, mode != M_RUN);
      chk("m_count", count, m_cnt);
      chk("m_full", full, m_full);
      if (e_instr_k) chk("m_instr", instr, e_instr);
      if (e_data_k) chk("m_data", data, e_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst = 0; start = 0; valid = 0; pend = 0; run = 0; rw = 0;
   endtask

   task automatic rst_pulse();
      clr();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic rnd(input int n);
      for (int k = 0; k < n; k++) begin
         rst = ($urandom_range(63) == 0);
         start = ($urandom_range(31) == 0);
         valid = 1'($urandom_range(1));
         pend = ($urandom_range(15) == 0);
         run = ($urandom_range(7) == 0);
         rw = 1'($urandom_range(1));
         ia = 8'($urandom);
         da = 8'($urandom_range(15));
         dw = 8'($urandom);
         pd = 9'($urandom);
         tick();
      end
      clr();
   endtask

   initial begin
      tick();
      tick();
      rst = 0;
      repeat (3) tick();
      chk("rst_cpu_rst", cpu_rst, 1'b1);
      chk("rst_instr", instr, 9'h1C0);
      chk("rst_data", data, 8'h00);
      chk("rst_count", count, 8'h00);
      chk("rst_full", full, 1'b0);
      start = 1; tick(); start = 0;
      valid = 1; pd = 9'h02F; tick();
      pd = 9'h024; tick();
      pd = 9'h0D4; tick();
      valid = 0; pend = 1; tick(); pend = 0;
      chk("load3_count", count, 8'd3);
      chk("end_cpu_rst", cpu_rst, 1'b0);
      chk("first_run_nop", instr, 9'h1C0);
      ia = 0; tick(); chk("fetch0", instr, 9'h02F);
      ia = 1; tick(); chk("fetch1", instr, 9'h024);
      ia = 2; tick(); chk("fetch2", instr, 9'h0D4);
      rw = 1; da = 8'h05; dw = 8'h03; tick(); chk("wr_first", data, 8'h03);
      rw = 0; tick(); chk("rd_after_wr", data, 8'h03);
      rst_pulse();
      rw = 1; dw = 8'hAA; tick(); tick();
      rw = 0; run = 1; tick(); run = 0;
      tick(); chk("idle_wr_ignored", data, 8'h03);
      rnd(400);
      rst_pulse();
      start = 1; tick(); start = 0;
      valid = 1;
      for (int i = 0; i < 256; i++) begin
         pd = 9'($urandom);
         tick();
      end
      valid = 0;
      chk("full_cpu_rst", cpu_rst, 1'b0);
      chk("full_flag", full, 1'b1);
      chk("full_count", count, 8'h00);
      for (int i = 0; i < 40; i++) begin
         ia = 8'($urandom);
         da = 8'($urandom_range(15));
         rw = 1'($urandom_range(1));
         dw = 8'($urandom);
         tick();
      end
      rst_pulse();
      start = 1; tick(); start = 0;
      valid = 1;
      for (int i = 0; i < 10; i++) begin
         w[i] = 9'($urandom);
         pd = w[i];
         tick();
      end
      valid = 0;
      rst = 1; tick(); rst = 0;
      chk("midload_rst_count", count, 8'h00);
      chk("midload_rst_cpu", cpu_rst, 1'b1);
      run = 1; tick(); run = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
         ia = 8'(i);
         tick();
         chk("kept_word", instr, w[i]);
      end
      rst_pulse();
      start = 1; tick();
      valid = 1; pd = 9'h1AA; tick();
      chk("restart_count", count, 8'h00);
      start = 0; valid = 0; pend = 1; tick(); pend = 0;
      ia = 0; tick();
      chk("restart_addr0", instr, w[0]);
      rnd(300);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/memoria_legion_h.md
# memoria_legion_h

Memory responder for the Legion H microprocessor. It sits on the far side of the processor's instruction and data buses. It serves 9-bit instruction fetches from an 8-bit instruction address and services 8-bit data reads and writes, with direction set by the read/write strobe. A sequential program loader fills instruction memory and holds the processor in reset until the program is in place.

## Interface
- ADDR_W, 8, instruction and data address width (256 words each)
- INSTR_W, 9, instruction word width
- DATA_W, 8, data word width
- NOP_INSTR, 9'b111000000, instruction presented to the CPU while it is not running

- i_Clk  in  1  system clock, rising edge
- i_Rst  in  1  asynchronous, active-high reset
- i_Direcciones_Instrucciones  in  ADDR_W  CPU instruction fetch address
- o_Instrucciones  out  INSTR_W  fetched instruction, to CPU
- i_Direcciones_Datos  in  ADDR_W  CPU data address
- i_Bus_Datos  in  DATA_W  CPU write data
- i_Lectura_Escritura  in  1  1 = write, 0 = read
- o_Bus_Datos  out  DATA_W  read data, to CPU
- o_Cpu_Rst  out  1  reset request to CPU; high except in RUN
- i_Prog_Start  in  1  begin or restart program load at address 0
- i_Prog_Valid  in  1  i_Prog_Data is valid this cycle
- i_Prog_Data  in  INSTR_W  program word
- i_Prog_End  in  1  finish loading and enter RUN
- i_Run  in  1  enter RUN from IDLE without loading
- o_Prog_Count  out  ADDR_W  next load address / words loaded mod 256
- o_Prog_Full  out  1  all 256 words written in the current load

## Operation
- States: IDLE, LOAD, RUN.
- Reset state is IDLE. Reset values: o_Cpu_Rst=1, o_Instrucciones=NOP_INSTR, o_Bus_Datos=0, o_Prog_Count=0, o_Prog_Full=0.
- Memory arrays are not cleared by reset. Reset in any state, including mid-load, returns to IDLE and keeps already-written words.
- IDLE:
  - i_Prog_Start -> LOAD, count=0, full=0.
  - else i_Run -> RUN.
  - i_Prog_Start has priority over i_Run.
- LOAD:
  - i_Prog_Start restarts: count=0, full=0. Any i_Prog_Valid in the same cycle is ignored.
  - Otherwise i_Prog_Valid writes instr_mem[count] and increments count.
  - A write at count=255 wraps count to 0, sets full and enters RUN.
  - i_Prog_End -> RUN. If i_Prog_Valid is also high, that word is written first.
- RUN:
  - o_Cpu_Rst=0.
  - i_Prog_Start -> LOAD (count=0, full=0), and o_Cpu_Rst rises.
  - i_Run and i_Prog_End have no effect.
- Outside RUN:
  - o_Instrucciones=NOP_INSTR.
  - CPU data writes are ignored.
  - o_Bus_Datos holds its last value.
- In RUN:
  - Read (i_Lectura_Escritura=0): o_Bus_Datos <= data_mem[addr].
  - Write (i_Lectura_Escritura=1): data_mem[addr] <= i_Bus_Datos, and o_Bus_Datos <= i_Bus_Datos (write-first).
- Addresses are full-width; no out-of-range case exists.

## Timing
- Instruction fetch: registered, 1-cycle latency. Address sampled at edge N; the word is valid after edge N.
- Data read: registered, 1-cycle latency.
- Data write: committed at the sampling edge. A read of the same address on the next edge returns the new value.
- o_Cpu_Rst is registered from the state and changes on the edge the state changes.
- On the first RUN cycle, o_Instrucciones still shows NOP_INSTR. The real fetch appears one edge later.
- Loader accepts one word per cycle; i_Prog_Valid may be held high continuously.
- o_Prog_Count and o_Prog_Full update on the same edge as the write.

## Structure
- Package legion_mem_pkg holds:
  - ADDR_W, INSTR_W, DATA_W defaults
  - NOP_INSTR
  - state typedef {IDLE, LOAD, RUN}
- Sub-module memoria_dp: generic simple dual-port synchronous RAM.
  - Parameters: width and depth.
  - One write port and one registered read port; write-first when addresses collide.
  - Instantiated twice:
    - Instructions: write port driven by the loader, read port by the fetch address.
    - Data: both ports driven by i_Direcciones_Datos.
- Top level holds the FSM, load counter, output muxing and the NOP/hold gating.

## Test plan
- Reset, then idle clocks -> o_Cpu_Rst=1, o_Instrucciones=9'b111000000, o_Bus_Datos=0, o_Prog_Count=0.
- Start; load 9'h02F, 9'h024, 9'h0D4 on consecutive cycles; End; fetch addresses 0..2 in RUN -> o_Prog_Count=3, o_Cpu_Rst falls on the End edge, words returned one cycle after each address.
- In RUN: write 8'h03 to address 8'h05, then read 8'h05 -> o_Bus_Datos=8'h03 on the write edge and again on the read edge. Write with the CPU held in IDLE -> memory unchanged.
- Load 256 words with i_Prog_Valid held high and no End -> RUN after the 256th word, o_Prog_Full=1, o_Prog_Count=0.
- Assert i_Rst after 10 load words -> IDLE, o_Cpu_Rst=1, count=0. Then i_Run -> fetches of addresses 0..9 return the loaded words.
- In LOAD, i_Prog_Start and i_Prog_Valid together with data 9'h1AA -> count=0, address 0 unchanged.
